// File: rtl/decoder_pkg.sv
// Shared types and helpers for the streaming one-hot decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    localparam int DEC_IN_W = 3;

    function automatic logic [2**DEC_IN_W-1:0] onehot_of(input logic [DEC_IN_W-1:0] code);
        onehot_of       = '0;
        onehot_of[code] = 1'b1;
    endfunction

endpackage

// File: rtl/onehot_decoder_stream_if.sv
// Input/output handshake bundle of the one-hot decoder; slave is the decoder side.
interface onehot_decoder_stream_if
    import decoder_pkg::*;
#(
    parameter int IN_W = DEC_IN_W
);
    localparam int OUT_W = 2**IN_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_onehot;
    logic [IN_W-1:0]  out_code;

    modport slave (
        input  in_valid, in_code, in_en, out_ready,
        output in_ready, out_valid, out_onehot, out_code
    );

    modport master (
        output in_valid, in_code, in_en, out_ready,
        input  in_ready, out_valid, out_onehot, out_code
    );
endinterface

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder; en=0 forces an all-zero word.
module onehot_dec #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]     code,
    input  logic                en,
    output logic [2**IN_W-1:0]  onehot
);
    genvar gi;
    generate
        for (gi = 0; gi < 2**IN_W; gi++) begin : g_bit
            assign onehot[gi] = en && (code == IN_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/onehot_decoder_stream.sv
// Streaming N-to-2^N one-hot decoder with a single registered output stage.
// Define DEC_SCAN_EN to build the self-test scan engine that walks every code.
module onehot_decoder_stream
    import decoder_pkg::*;
#(
    parameter int IN_W     = DEC_IN_W,
    parameter int SCAN_GAP = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    onehot_decoder_stream_if.slave bus,
    input  logic                   scan_start,
    output logic                   scan_busy
);
    localparam int OUT_W = 2**IN_W;

    logic             out_valid_reg;
    logic [OUT_W-1:0] out_onehot_reg;
    logic [IN_W-1:0]  out_code_reg;

    logic             in_ready;
    logic             in_fire;
    logic             out_fire;
    logic             load_beat;
    logic             scan_load;
    logic             use_scan;
    logic [IN_W-1:0]  scan_code;
    logic [IN_W-1:0]  dec_code;
    logic             dec_en;
    logic [OUT_W-1:0] dec_onehot;

    assign out_fire  = out_valid_reg && bus.out_ready;
    assign in_fire   = bus.in_valid && in_ready;
    assign load_beat = in_fire || scan_load;

    // One decoder serves both sources; scan beats always decode enabled.
    assign dec_code = use_scan ? scan_code : bus.in_code;
    assign dec_en   = use_scan || bus.in_en;

    onehot_dec #(.IN_W(IN_W)) u_dec (
        .code   (dec_code),
        .en     (dec_en),
        .onehot (dec_onehot)
    );

`ifdef DEC_SCAN_EN
    scan_state_t     state_reg;
    logic [IN_W-1:0] counter_reg;
    logic [7:0]      gap_reg;
    logic            scan_go;
    logic            last_beat;
    logic            gap_done;

    assign scan_go   = (state_reg == IDLE) && scan_start && (!out_valid_reg || bus.out_ready);
    assign last_beat = counter_reg == {IN_W{1'b1}};
    assign gap_done  = gap_reg == 8'(SCAN_GAP - 1);
    assign in_ready  = !rst && (state_reg == IDLE) && !scan_start && (!out_valid_reg || bus.out_ready);
    assign scan_busy = state_reg != IDLE;
    assign use_scan  = scan_go || (state_reg != IDLE);

    // scan_code is the code of the beat that would be loaded this cycle.
    always_comb begin
        scan_load = 1'b0;
        scan_code = counter_reg;
        case (state_reg)
            IDLE: begin
                scan_load = scan_go;
                scan_code = '0;
            end
            EMIT: begin
                scan_load = out_fire && !last_beat && (SCAN_GAP == 0);
                scan_code = counter_reg + 1'b1;
            end
            GAP: scan_load = gap_done;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            gap_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (scan_go) begin
                        state_reg   <= EMIT;
                        counter_reg <= '0;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (last_beat) begin
                            state_reg <= IDLE;
                        end else begin
                            counter_reg <= counter_reg + 1'b1;
                            if (SCAN_GAP > 0) begin
                                state_reg <= GAP;
                                gap_reg   <= '0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_done) state_reg <= EMIT;
                    else          gap_reg   <= gap_reg + 8'd1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
`else
    logic unused_scan;

    assign in_ready    = !rst && (!out_valid_reg || bus.out_ready);
    assign scan_busy   = 1'b0;
    assign scan_load   = 1'b0;
    assign use_scan    = 1'b0;
    assign scan_code   = '0;
    assign unused_scan = scan_start | (SCAN_GAP != 0);
`endif

    // A beat that leaves without a replacement clears the register to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_onehot_reg <= '0;
            out_code_reg   <= '0;
        end else if (load_beat) begin
            out_valid_reg  <= 1'b1;
            out_onehot_reg <= dec_onehot;
            out_code_reg   <= dec_code;
        end else if (out_fire) begin
            out_valid_reg  <= 1'b0;
            out_onehot_reg <= '0;
            out_code_reg   <= '0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_onehot = out_onehot_reg;
    assign bus.out_code   = out_code_reg;

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Randomized self-checking bench for onehot_decoder_stream against a queue model.
module tb_onehot_decoder_stream;

    localparam int GAP    = 2;
    localparam int PERIOD = 1 + GAP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scan_start = 1'b0;
    logic scan_busy;

    always #5 clk = ~clk;

    onehot_decoder_stream_if #(.IN_W(3)) dif ();

    onehot_decoder_stream #(.IN_W(3), .SCAN_GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (dif),
        .scan_start (scan_start),
        .scan_busy  (scan_busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [7:0] oh;
        logic [2:0] code;
    } beat_t;

    beat_t q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check just after, then advance the model.
    task automatic step(input logic v, input logic [2:0] code, input logic en,
                        input logic ordy, input logic ss);
        logic  exp_ready;
        beat_t b;
        @(negedge clk);
        dif.in_valid  = v;
        dif.in_code   = code;
        dif.in_en     = en;
        dif.out_ready = ordy;
        scan_start    = ss;
        #1;
        exp_ready = (q.size() == 0) || ordy;
        check_eq("in_ready", 32'(dif.in_ready), 32'(exp_ready));
        check_eq("out_valid", 32'(dif.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_eq("out_onehot", 32'(dif.out_onehot), 32'(q[0].oh));
            check_eq("out_code", 32'(dif.out_code), 32'(q[0].code));
        end else begin
            check_eq("idle_onehot", 32'(dif.out_onehot), 32'h0);
            check_eq("idle_code", 32'(dif.out_code), 32'h0);
        end
        check_eq("scan_busy_idle", 32'(scan_busy), 32'h0);
        if (q.size() != 0 && ordy) begin
            b = q.pop_front();
            $display("[TB] beat code=%0d onehot=%02h", b.code, b.oh);
        end
        if (v && exp_ready) begin
            b.code = code;
            b.oh   = en ? 8'(1 << code) : 8'h00;
            q.push_back(b);
        end
    endtask

    task automatic reset_and_resume();
        #1;
        rst          = 1'b1;
        dif.in_valid = 1'b0;
        scan_start   = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(dif.out_valid), 32'h0);
        check_eq("rst_out_onehot", 32'(dif.out_onehot), 32'h0);
        check_eq("rst_scan_busy", 32'(scan_busy), 32'h0);
        check_eq("rst_in_ready", 32'(dif.in_ready), 32'h0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        $display("[TB] resumed after reset, code 7 checked");
    endtask

`ifdef DEC_SCAN_EN
    // Runs a scan for last_j cycles after the start pulse; beat k is valid on cycle 1+k*PERIOD.
    task automatic run_scan(input int last_j);
        @(negedge clk);
        scan_start    = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_code   = 3'd6;
        dif.in_en     = 1'b1;
        dif.out_ready = 1'b1;
        #1;
        check_eq("scan_start_in_ready", 32'(dif.in_ready), 32'h0);
        for (int j = 1; j <= last_j; j++) begin
            @(negedge clk);
            scan_start   = 1'b0;
            dif.in_valid = (j <= 8 * PERIOD - GAP) ? 1'($urandom_range(0, 1)) : 1'b0;
            dif.in_code  = 3'($urandom_range(0, 7));
            #1;
            if (j <= 8 * PERIOD - GAP) begin
                int k = (j - 1) / PERIOD;
                logic on = ((j - 1) % PERIOD) == 0;
                check_eq("scan_busy", 32'(scan_busy), 32'h1);
                check_eq("scan_in_ready", 32'(dif.in_ready), 32'h0);
                check_eq("scan_out_valid", 32'(dif.out_valid), 32'(on));
                check_eq("scan_onehot", 32'(dif.out_onehot), on ? 32'(1 << k) : 32'h0);
                check_eq("scan_code", 32'(dif.out_code), on ? 32'(k) : 32'h0);
                if (on) $display("[TB] scan beat code=%0d onehot=%02h", k, dif.out_onehot);
            end else begin
                check_eq("scan_done_busy", 32'(scan_busy), 32'h0);
                check_eq("scan_done_in_ready", 32'(dif.in_ready), 32'h1);
                check_eq("scan_done_valid", 32'(dif.out_valid), 32'h0);
            end
        end
    endtask
`endif

    initial begin
        dif.in_valid  = 1'b1;
        dif.in_code   = 3'd0;
        dif.in_en     = 1'b1;
        dif.out_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_eq("reset_out_valid", 32'(dif.out_valid), 32'h0);
            check_eq("reset_out_onehot", 32'(dif.out_onehot), 32'h0);
            check_eq("reset_in_ready", 32'(dif.in_ready), 32'h0);
            check_eq("reset_scan_busy", 32'(scan_busy), 32'h0);
        end
        @(negedge clk);
        rst          = 1'b0;
        dif.in_valid = 1'b0;
        #1;
        check_eq("release_in_ready", 32'(dif.in_ready), 32'h1);

        for (int c = 0; c < 8; c++) step(1'b1, 3'(c), 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);

        step(1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);

        step(1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);

`ifndef DEC_SCAN_EN
        step(1'b1, 3'd1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);

        step(1'b1, 3'd4, 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        reset_and_resume();

`ifdef DEC_SCAN_EN
        run_scan(8 * PERIOD - GAP + 1);
        run_scan(1 + 3 * PERIOD);
        check_eq("midscan_onehot", 32'(dif.out_onehot), 32'h08);
        reset_and_resume();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
